// File: rtl/abejaruco_mem_pkg.sv
// abejaruco_mem_pkg
//   Shared definitions for the memory subsystem: arbiter FSM state
//   encoding, memory operation codes and arbiter grant identifiers.
//   Imported by the arbiter, its picker, the memory and the caches.
package abejaruco_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mem_state_t;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    // Identifies which requester owns (or last owned) the memory port.
    localparam logic GRANT_DC = 1'b0;
    localparam logic GRANT_IC = 1'b1;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker
//   Combinational winner selection between the instruction cache and the
//   data cache.
//   Ports:
//     ic_req, dc_req  in  pending requests
//     last_grant      in  owner of the previous grant (GRANT_IC / GRANT_DC)
//     grant_ic        out ic wins this arbitration
//     grant_dc        out dc wins this arbitration
//   Macro ARBITER_ROUND_ROBIN_EN: when defined, contention goes to the port
//   that was not granted last; otherwise dc always beats ic.
module mem_arb_picker
    import abejaruco_mem_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_grant,
    output logic grant_ic,
    output logic grant_dc
);

    logic prefer_ic;

`ifdef ARBITER_ROUND_ROBIN_EN
    assign prefer_ic = (last_grant == GRANT_DC);
`else
    // Fixed priority ignores history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign prefer_ic         = 1'b0;
`endif

    assign grant_ic = ic_req & (~dc_req |  prefer_ic);
    assign grant_dc = dc_req & (~ic_req | ~prefer_ic);

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one memory port between the instruction cache (read-only) and
//   the data cache (read/write). One transaction at a time:
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     ic_req/ic_addr                 ic request; ic_data/ic_ready response
//     dc_req/dc_op/dc_addr/dc_wdata  dc request; dc_data/dc_ready response
//     mem_enable/mem_op/mem_op_init/mem_op_done/mem_address/mem_data_in
//                                    memory request side
//     mem_data_out/mem_data_ready    memory response side
//   Macro ARBITER_ROUND_ROBIN_EN selects round-robin arbitration (default:
//   dc has fixed priority over ic).
module memory_arbiter
    import abejaruco_mem_pkg::*;
#(
    parameter int ADDRESS_SIZE    = 12,
    parameter int CACHE_LINE_SIZE = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ic_req,
    input  logic [ADDRESS_SIZE-1:0]    ic_addr,
    output logic [CACHE_LINE_SIZE-1:0] ic_data,
    output logic                       ic_ready,
    input  logic                       dc_req,
    input  logic                       dc_op,
    input  logic [ADDRESS_SIZE-1:0]    dc_addr,
    input  logic [CACHE_LINE_SIZE-1:0] dc_wdata,
    output logic [CACHE_LINE_SIZE-1:0] dc_data,
    output logic                       dc_ready,
    output logic                       mem_enable,
    output logic                       mem_op,
    output logic                       mem_op_init,
    output logic                       mem_op_done,
    output logic [ADDRESS_SIZE-1:0]    mem_address,
    output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
    input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
    input  logic                       mem_data_ready
);

    mem_state_t                 state_q, state_d;
    logic                       grant_ic, grant_dc;
    logic                       last_grant_q;
    logic                       owner_q;
    logic                       op_q;
    logic [ADDRESS_SIZE-1:0]    addr_q;
    logic [CACHE_LINE_SIZE-1:0] wdata_q;
    // Memory response is registered at the boundary; the FSM acts on the
    // registered copy, which adds one cycle between mem_data_ready rising
    // and the ready pulse.
    logic                       rdy_q;
    logic [CACHE_LINE_SIZE-1:0] rdata_q;
    logic [CACHE_LINE_SIZE-1:0] ic_data_q, dc_data_q;
    logic                       ic_ready_q, dc_ready_q;

    mem_arb_picker u_picker (
        .ic_req     (ic_req),
        .dc_req     (dc_req),
        .last_grant (last_grant_q),
        .grant_ic   (grant_ic),
        .grant_dc   (grant_dc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_ic || grant_dc) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (rdy_q) state_d = ST_DONE;
            // Stay until memory drops ready so no grant overlaps its tail.
            ST_DONE:  if (!rdy_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_enable  = 1'b0;
        mem_op_init = 1'b0;
        mem_op_done = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                mem_enable  = 1'b1;
                mem_op_init = 1'b1;
            end
            ST_WAIT:  mem_enable  = 1'b1;
            ST_DONE:  mem_op_done = 1'b1;
            default: ;
        endcase
    end

    // Request latch, response capture and ready pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_IC;   // dc wins the first contention
            owner_q      <= GRANT_DC;
            op_q         <= MEM_OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdy_q        <= 1'b0;
            rdata_q      <= '0;
            ic_data_q    <= '0;
            dc_data_q    <= '0;
            ic_ready_q   <= 1'b0;
            dc_ready_q   <= 1'b0;
        end else begin
            rdy_q      <= mem_data_ready;
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
            if (mem_data_ready) rdata_q <= mem_data_out;

            if (state_q == ST_IDLE && (grant_ic || grant_dc)) begin
                owner_q      <= grant_ic ? GRANT_IC : GRANT_DC;
                last_grant_q <= grant_ic ? GRANT_IC : GRANT_DC;
                op_q         <= grant_ic ? MEM_OP_READ : dc_op;
                addr_q       <= grant_ic ? ic_addr : dc_addr;
                wdata_q      <= grant_ic ? '0 : dc_wdata;
            end

            if (state_q == ST_WAIT && rdy_q) begin
                if (owner_q == GRANT_IC) begin
                    ic_ready_q <= 1'b1;
                    ic_data_q  <= rdata_q;
                end else begin
                    dc_ready_q <= 1'b1;
                    if (op_q == MEM_OP_READ) dc_data_q <= rdata_q;
                end
            end
        end
    end

    assign mem_op      = op_q;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;
    assign ic_data     = ic_data_q;
    assign dc_data     = dc_data_q;
    assign ic_ready    = ic_ready_q;
    assign dc_ready    = dc_ready_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Random and directed transactions against memory_arbiter with a
//   behavioural memory and a transaction-level reference model (grant
//   order + shadow memory contents).
//   Macro ARBITER_ROUND_ROBIN_EN selects the expected arbitration policy.
module tb_memory_arbiter;

    localparam int AW = 12;
    localparam int LW = 128;
    localparam int OP_DELAY = 3;

`ifdef ARBITER_ROUND_ROBIN_EN
    localparam logic [3:0] EXP_CONT = 4'b0101;  // dc, ic, dc, ic
`else
    localparam logic [3:0] EXP_CONT = 4'b0011;  // dc, dc, ic, ic
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req, dc_req, dc_op;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata, ic_data, dc_data;
    logic          ic_ready, dc_ready;
    logic          mem_enable, mem_op, mem_op_init, mem_op_done;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_data_in, mem_data_out;
    logic          mem_data_ready;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_data        (ic_data),
        .ic_ready       (ic_ready),
        .dc_req         (dc_req),
        .dc_op          (dc_op),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .dc_data        (dc_data),
        .dc_ready       (dc_ready),
        .mem_enable     (mem_enable),
        .mem_op         (mem_op),
        .mem_op_init    (mem_op_init),
        .mem_op_done    (mem_op_done),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_ready (mem_data_ready)
    );

    function automatic logic [LW-1:0] init_line(input logic [4:0] i);
        if (i == 5'd4) return {16{8'hA5}};
        return {4{24'hC0FFEE, 3'b000, i}};
    endfunction

    // ---------------- behavioural memory ----------------
    logic [LW-1:0] store [0:31];
    bit            store_vld [0:31];
    int            cnt, hold_left;
    int            hold_extra = 0;
    logic          s_op;
    logic [4:0]    s_idx;
    logic [LW-1:0] s_wd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= 0;
            hold_left      <= 0;
            mem_data_ready <= 1'b0;
        end else if (mem_op_init) begin
            cnt   <= OP_DELAY;
            s_idx <= mem_address[8:4];
            s_op  <= mem_op;
            s_wd  <= mem_data_in;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mem_data_ready <= 1'b1;
                hold_left      <= hold_extra;
                if (s_op) begin
                    store[s_idx]     <= s_wd;
                    store_vld[s_idx] <= 1'b1;
                    mem_data_out     <= ~s_wd;   // junk: must not reach dc_data
                end else begin
                    mem_data_out <= store_vld[s_idx] ? store[s_idx] : init_line(s_idx);
                end
            end
        end else if (mem_data_ready && mem_op_done) begin
            if (hold_left != 0) hold_left <= hold_left - 1;
            else                mem_data_ready <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int            init_cnt = 0, ic_pulses = 0, dc_pulses = 0;
    int            stab_err = 0, proto_err = 0;
    logic          prev_ic = 1'b0, prev_dc = 1'b0;
    logic [AW-1:0] lat_addr = '0;
    logic          lat_op = 1'b0;
    logic [LW-1:0] lat_wd = '0;
    wire proto_bad = (mem_op_init && (mem_op_done || mem_data_ready || !mem_enable)) ||
                     (mem_data_ready && !mem_enable && !mem_op_done) ||
                     (ic_ready && prev_ic) || (dc_ready && prev_dc) ||
                     (ic_ready && dc_ready);

    always @(negedge clk) begin
        prev_ic <= ic_ready;
        prev_dc <= dc_ready;
        if (ic_ready) ic_pulses <= ic_pulses + 1;
        if (dc_ready) dc_pulses <= dc_pulses + 1;
        if (rst_n) begin
            if (mem_op_init) begin
                init_cnt <= init_cnt + 1;
                lat_addr <= mem_address;
                lat_op   <= mem_op;
                lat_wd   <= mem_data_in;
            end else if (mem_enable && (mem_address !== lat_addr || mem_op !== lat_op ||
                                        mem_data_in !== lat_wd)) begin
                stab_err <= stab_err + 1;
            end
            if (proto_bad) proto_err <= proto_err + 1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic          is_ic;
        logic          op;
        logic [AW-1:0] addr;
        logic [LW-1:0] wd;
        logic [LW-1:0] rd;
    } txn_t;

    txn_t          ic_q[$], dc_q[$], exp_q[$];
    logic [LW-1:0] shadow [0:31];
    logic          m_last_ic;
    logic [LW-1:0] m_ic_data, m_dc_data;
    int            first_lat;
    logic [7:0]    obs_seq;

    function automatic txn_t mk(input logic is_ic, input logic op, input logic [AW-1:0] a,
                                input logic [LW-1:0] wd);
        txn_t t;
        t.is_ic = is_ic; t.op = op; t.addr = a; t.wd = wd; t.rd = '0;
        return t;
    endfunction

    task automatic model_reset();
        m_last_ic = 1'b1;
        m_ic_data = '0;
        m_dc_data = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, LW'({mem_enable, mem_op, mem_op_init, mem_op_done, ic_ready, dc_ready}), '0);
        chk({tag, "_addr"}, LW'(mem_address), '0);
        chk({tag, "_wdata"}, mem_data_in, '0);
        chk({tag, "_ic_data"}, ic_data, '0);
        chk({tag, "_dc_data"}, dc_data, '0);
    endtask

    // Serves everything in ic_q/dc_q; each port re-requests the moment its
    // previous ready pulse is seen. Starts and ends on a falling edge.
    task automatic run_round(input int hold);
        txn_t e;
        int   ii, jj, g, r, cyc, total, ic0, dc0, in0;
        logic pick;
        hold_extra = hold;
        exp_q.delete();
        ii = 0; jj = 0;
        while (ii < ic_q.size() || jj < dc_q.size()) begin
            if (ii < ic_q.size() && jj < dc_q.size()) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                pick = !m_last_ic;
`else
                pick = 1'b0;
`endif
            end else begin
                pick = (ii < ic_q.size());
            end
            if (pick) begin e = ic_q[ii]; ii++; end
            else      begin e = dc_q[jj]; jj++; end
            if (e.op) shadow[e.addr[8:4]] = e.wd;
            else      e.rd = shadow[e.addr[8:4]];
            m_last_ic = pick;
            exp_q.push_back(e);
        end
        total = exp_q.size();
        ic0 = ic_pulses; dc0 = dc_pulses; in0 = init_cnt;

        ic_req = (ic_q.size() != 0);
        if (ic_req) ic_addr = ic_q[0].addr;
        dc_req = (dc_q.size() != 0);
        if (dc_req) begin dc_op = dc_q[0].op; dc_addr = dc_q[0].addr; dc_wdata = dc_q[0].wd; end

        g = 0; r = 0; cyc = 0; obs_seq = '0;
        while (r < total && cyc < 40 * total + 20) begin
            @(negedge clk);
            cyc++;
            if (mem_op_init && g < total) begin
                chk("grant_addr", LW'(mem_address), LW'(exp_q[g].addr));
                chk("grant_op", LW'(mem_op), LW'(exp_q[g].op));
                if (exp_q[g].op) chk("grant_wdata", mem_data_in, exp_q[g].wd);
                g++;
            end
            if (ic_ready || dc_ready) begin
                e = exp_q[r];
                r++;
                if (r == 1) first_lat = cyc;
                obs_seq = {obs_seq[6:0], ic_ready};
                chk("ready_port", LW'(ic_ready), LW'(e.is_ic));
                if (e.is_ic) begin
                    m_ic_data = e.rd;
                    chk("ic_data", ic_data, m_ic_data);
                end else begin
                    if (!e.op) m_dc_data = e.rd;
                    chk("dc_data", dc_data, m_dc_data);
                end
                if (ic_ready && ic_q.size() != 0) begin
                    void'(ic_q.pop_front());
                    ic_req = (ic_q.size() != 0);
                    if (ic_req) ic_addr = ic_q[0].addr;
                end
                if (dc_ready && dc_q.size() != 0) begin
                    void'(dc_q.pop_front());
                    dc_req = (dc_q.size() != 0);
                    if (dc_req) begin
                        dc_op = dc_q[0].op; dc_addr = dc_q[0].addr; dc_wdata = dc_q[0].wd;
                    end
                end
            end
        end
        if (r < total) chk("round_timeout", LW'(r), LW'(total));
        ic_req = 1'b0; dc_req = 1'b0;
        ic_q.delete(); dc_q.delete();

        cyc = 0;
        while ((mem_op_done || mem_enable || mem_data_ready) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) chk("drain_timeout", LW'(cyc), '0);
        repeat (2) @(negedge clk);
        chk("init_pulses", LW'(init_cnt - in0), LW'(total));
        chk("ic_pulses", LW'(ic_pulses - ic0), LW'(total - (dc_pulses - dc0)));
        chk("ic_other_data", ic_data, m_ic_data);
        chk("dc_other_data", dc_data, m_dc_data);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [LW-1:0] W26 = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_EEFF;

    initial begin
        int p0, nic, ndc;
        for (int i = 0; i < 32; i++) shadow[i] = init_line(5'(i));
        ic_req = 1'b0; dc_req = 1'b0; dc_op = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        first_lat = 0;
        model_reset();

        #3 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Contention twice in a row, straight after reset
        ic_q.push_back(mk(1'b1, 1'b0, 12'h080, '0));
        ic_q.push_back(mk(1'b1, 1'b0, 12'h090, '0));
        dc_q.push_back(mk(1'b0, 1'b0, 12'h0A0, '0));
        dc_q.push_back(mk(1'b0, 1'b0, 12'h0B0, '0));
        run_round(0);
        chk("contention_order", LW'(obs_seq[3:0]), LW'(EXP_CONT));

        // ic read of the A5 line: latency and data
        ic_q.push_back(mk(1'b1, 1'b0, 12'h040, '0));
        run_round(0);
        chk("ic_latency", LW'(first_lat), LW'(7));
        chk("ic_a5_data", ic_data, {16{8'hA5}});

        // dc write then read back
        dc_q.push_back(mk(1'b0, 1'b1, 12'h100, W26));
        run_round(1);
        dc_q.push_back(mk(1'b0, 1'b0, 12'h100, '0));
        run_round(0);
        chk("dc_readback", dc_data, W26);

        // Reset in the second WAIT cycle, ic_req held throughout
        ic_req = 1'b1; ic_addr = 12'h050;
        repeat (3) @(negedge clk);
        chk("mid_wait_enable", LW'(mem_enable), LW'(1'b1));
        chk("mid_wait_no_init", LW'(mem_op_init), '0);
        p0 = ic_pulses + dc_pulses;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset_mid");
        repeat (3) @(negedge clk);
        chk("reset_no_pulse", LW'(ic_pulses + dc_pulses - p0), '0);
        rst_n = 1'b1;
        model_reset();
        ic_q.push_back(mk(1'b1, 1'b0, 12'h050, '0));
        run_round(0);
        chk("post_reset_latency", LW'(first_lat), LW'(7));

        // Memory holds ready three extra cycles
        ic_q.push_back(mk(1'b1, 1'b0, 12'h040, '0));
        dc_q.push_back(mk(1'b0, 1'b0, 12'h060, '0));
        run_round(3);

        // Random rounds
        for (int k = 0; k < 20; k++) begin
            nic = $urandom_range(0, 2);
            ndc = $urandom_range(0, 2);
            if (nic == 0 && ndc == 0) nic = 1;
            for (int i = 0; i < nic; i++)
                ic_q.push_back(mk(1'b1, 1'b0, AW'($urandom_range(0, 31) * 16), '0));
            for (int i = 0; i < ndc; i++)
                dc_q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31) * 16),
                                  {$urandom, $urandom, $urandom, $urandom}));
            run_round(int'($urandom_range(0, 3)));
        end

        chk("addr_data_stable", LW'(stab_err), '0);
        chk("handshake_protocol", LW'(proto_err), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 12, byte address width.
REQ-002 SHALL have parameter CACHE_LINE_SIZE, default 128, line width in bits.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: ic_req  in  1 / ic_addr  in  ADDRESS_SIZE / ic_data  out  CACHE_LINE_SIZE / ic_ready  out  1; instruction-cache read-only requester.
REQ-006 SHALL have ports: dc_req  in  1 / dc_op  in  1 (0 read, 1 write) / dc_addr  in  ADDRESS_SIZE / dc_wdata  in  CACHE_LINE_SIZE / dc_data  out  CACHE_LINE_SIZE / dc_ready  out  1; data-cache requester.
REQ-007 SHALL have ports: mem_enable, mem_op, mem_op_init, mem_op_done  out  1; mem_address  out  ADDRESS_SIZE; mem_data_in  out  CACHE_LINE_SIZE; mem_data_out  in  CACHE_LINE_SIZE; mem_data_ready  in  1; memory-side handshake.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-009 IDLE: on any pending request SHALL pick a winner, latch its op/addr/wdata into registers, go to ISSUE next cycle; no request -> stay in IDLE.
REQ-010 ISSUE: SHALL drive mem_enable=1 and mem_op_init=1 for exactly one cycle, then go to WAIT.
REQ-011 WAIT: SHALL hold mem_enable=1 and mem_op/mem_address/mem_data_in stable until mem_data_ready=1 is sampled.
REQ-012 On sampling mem_data_ready=1: SHALL register mem_data_out into the winner's data output (reads only), pulse the winner's ready for one cycle, drop mem_enable, go to DONE.
REQ-013 DONE: SHALL assert mem_op_done until mem_data_ready=0 is sampled, then go to IDLE; a new grant SHALL NOT occur before that.
REQ-014 Latency: read completes (ready pulse) 2 cycles after mem_data_ready rises relative to ISSUE entry + memory delay; with OP_DELAY_CYCLES=3, ic_req in cycle 0 -> ic_ready in cycle 7.
REQ-015 Requesters SHALL hold req until their ready pulse; a req dropped before grant is ignored; a req dropped after grant does not abort the transaction.
REQ-016 ic_data/dc_data SHALL hold their last value until the next completed read for that port; dc write completions pulse dc_ready with dc_data unchanged.
REQ-017 Simultaneous ic_req and dc_req in IDLE: winner per REQ-022; loser stays pending and is served next.
REQ-018 ic requests SHALL always drive mem_op=0.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE and all outputs 0 (mem_enable, mem_op, mem_op_init, mem_op_done, mem_address, mem_data_in, ic_data, dc_data, ic_ready, dc_ready).
REQ-020 Reset mid-transaction SHALL abandon it without a ready pulse; no request is replayed after reset.
REQ-021 Priority pointer SHALL reset to favour dc.

Configuration
REQ-022 ARBITER_ROUND_ROBIN_EN defined: on contention the port not granted last wins; undefined: dc always wins over ic (fixed priority).

Structure
REQ-023 Shared package abejaruco_mem_pkg SHALL hold FSM state encodings and MEM_OP_READ=0/MEM_OP_WRITE=1 constants, reused by memory and caches.
REQ-024 Winner selection SHALL be sub-module mem_arb_picker (inputs ic_req, dc_req, last_grant; outputs grant_ic, grant_dc), combinational.

Verification
REQ-025 ic_req=1, ic_addr=0x040, memory holds line 0xA5..A5 -> ic_ready single pulse, ic_data=0xA5..A5, mem_op_init exactly one pulse.
REQ-026 dc_req=1, dc_op=1, dc_addr=0x100, dc_wdata=0x1122..FF -> mem_op=1 through WAIT, dc_ready pulse; subsequent dc read of 0x100 returns 0x1122..FF.
REQ-027 ic_req and dc_req asserted same cycle twice in a row -> with macro: dc then ic then dc then ic; without: dc, dc, then ic.
REQ-028 rst_n low in WAIT cycle 2 -> all outputs 0 same cycle, no ready pulse; after release, held ic_req is served normally.
REQ-029 mem_data_ready held high 3 extra cycles -> mem_op_done held high throughout, no new mem_op_init until it falls.
